// File: rtl/cpu_defs.sv
// Shared encodings for the multicycle controller: widths, states, ALU ops,
// instruction op/ext fields, condition codes, PSR bit positions, mux selects.
package cpu_defs;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned PC_W   = 16;

    typedef enum logic [2:0] {
        ST_FETCH   = 3'b000,
        ST_DECODE  = 3'b001,
        ST_EXEC    = 3'b010,
        ST_LOAD_WB = 3'b011
    } state_e;

    // ALU control codes
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_OR   = 4'b0100;
    localparam logic [3:0] ALU_CMP  = 4'b0101;
    localparam logic [3:0] ALU_MOV  = 4'b0110;
    localparam logic [3:0] ALU_LSH  = 4'b0111;
    localparam logic [3:0] ALU_LSHI = 4'b1000;
    localparam logic [3:0] ALU_LUI  = 4'b1001;
    localparam logic [3:0] ALU_RANI = 4'b1111;

    // Primary opcode IR[15:12]
    localparam logic [3:0] OP_REG   = 4'b0000;
    localparam logic [3:0] OP_ANDI  = 4'b0001;
    localparam logic [3:0] OP_ORI   = 4'b0010;
    localparam logic [3:0] OP_XORI  = 4'b0011;
    localparam logic [3:0] OP_MEM   = 4'b0100;
    localparam logic [3:0] OP_ADDI  = 4'b0101;
    localparam logic [3:0] OP_SHIFT = 4'b1000;
    localparam logic [3:0] OP_SUBI  = 4'b1001;
    localparam logic [3:0] OP_CMPI  = 4'b1011;
    localparam logic [3:0] OP_BCOND = 4'b1100;
    localparam logic [3:0] OP_MOVI  = 4'b1101;
    localparam logic [3:0] OP_RANI  = 4'b1110;
    localparam logic [3:0] OP_LUI   = 4'b1111;

    // Extended opcode IR[7:4]
    localparam logic [3:0] EXT_AND   = 4'b0001;
    localparam logic [3:0] EXT_OR    = 4'b0010;
    localparam logic [3:0] EXT_XOR   = 4'b0011;
    localparam logic [3:0] EXT_ADD   = 4'b0101;
    localparam logic [3:0] EXT_SUB   = 4'b1001;
    localparam logic [3:0] EXT_CMP   = 4'b1011;
    localparam logic [3:0] EXT_MOV   = 4'b1101;
    localparam logic [3:0] EXT_LSH   = 4'b0100;
    localparam logic [3:0] EXT_LOAD  = 4'b0000;
    localparam logic [3:0] EXT_STOR  = 4'b0100;
    localparam logic [3:0] EXT_JAL   = 4'b1000;
    localparam logic [3:0] EXT_JCOND = 4'b1100;

    // Branch/jump condition codes
    localparam logic [3:0] CC_EQ = 4'b0000;
    localparam logic [3:0] CC_NE = 4'b0001;
    localparam logic [3:0] CC_CS = 4'b0010;
    localparam logic [3:0] CC_CC = 4'b0011;
    localparam logic [3:0] CC_HI = 4'b0100;
    localparam logic [3:0] CC_LS = 4'b0101;
    localparam logic [3:0] CC_GT = 4'b0110;
    localparam logic [3:0] CC_LE = 4'b0111;
    localparam logic [3:0] CC_FS = 4'b1000;
    localparam logic [3:0] CC_FC = 4'b1001;
    localparam logic [3:0] CC_LO = 4'b1010;
    localparam logic [3:0] CC_HS = 4'b1011;
    localparam logic [3:0] CC_LT = 4'b1100;
    localparam logic [3:0] CC_GE = 4'b1101;
    localparam logic [3:0] CC_UC = 4'b1110;

    // PSR bit positions
    localparam int unsigned PSR_C = 0;
    localparam int unsigned PSR_F = 1;
    localparam int unsigned PSR_L = 2;
    localparam int unsigned PSR_Z = 3;
    localparam int unsigned PSR_N = 4;

    // Datapath mux selects
    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_MEM  = 2'b01;
    localparam logic [1:0] WB_PC1  = 2'b10;
    localparam logic [1:0] PC_INC  = 2'b00;
    localparam logic [1:0] PC_DISP = 2'b01;
    localparam logic [1:0] PC_REG  = 2'b10;

endpackage

// File: rtl/cond_eval.sv
// Branch/jump condition evaluation against the latched PSR.
module cond_eval
    import cpu_defs::*;
(
    input  logic [3:0] cond_i,
    input  logic [4:0] psr_i,
    output logic       taken_o
);

    logic c, f, l, z, n;
    assign c = psr_i[PSR_C];
    assign f = psr_i[PSR_F];
    assign l = psr_i[PSR_L];
    assign z = psr_i[PSR_Z];
    assign n = psr_i[PSR_N];

    // Condition code to taken decision; 1111 is never taken
    always_comb begin
        taken_o = 1'b0;
        case (cond_i)
            CC_EQ:   taken_o = z;
            CC_NE:   taken_o = !z;
            CC_CS:   taken_o = c;
            CC_CC:   taken_o = !c;
            CC_HI:   taken_o = l;
            CC_LS:   taken_o = !l;
            CC_GT:   taken_o = n;
            CC_LE:   taken_o = !n;
            CC_FS:   taken_o = f;
            CC_FC:   taken_o = !f;
            CC_LO:   taken_o = !l && !z;
            CC_HS:   taken_o = l || z;
            CC_LT:   taken_o = !n && !z;
            CC_GE:   taken_o = n || z;
            CC_UC:   taken_o = 1'b1;
            default: taken_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/cpu_controller.sv
// Multicycle fetch/decode/execute controller for the CR16-style datapath.
// Owns the IR and the architectural PSR; datapath controls are decoded from
// state and IR each cycle and forced idle while reset is asserted.
module cpu_controller
    import cpu_defs::*;
#(
    parameter int unsigned WIDTH = DATA_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic [4:0]       psr_in,
    output logic [3:0]       alucont,
    output logic [3:0]       rdest_sel,
    output logic [3:0]       rsrc_sel,
    output logic [WIDTH-1:0] imm,
    output logic             use_imm,
    output logic             reg_we,
    output logic [1:0]       wb_sel,
    output logic             ir_en,
    output logic             addr_sel,
    output logic             mem_we,
    output logic             pc_en,
    output logic [1:0]       pc_sel,
    output logic [4:0]       psr_q,
    output logic [2:0]       state_dbg
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] ir_q;
    logic [4:0]       psr_d;
    logic [3:0]       op, ext;
    logic [7:0]       imm8;
    logic [WIDTH-1:0] imm_s, imm_z, imm_sh;
    logic             taken;

    assign op        = ir_q[15:12];
    assign ext       = ir_q[7:4];
    assign imm8      = ir_q[7:0];
    assign rdest_sel = ir_q[11:8];
    assign rsrc_sel  = ir_q[3:0];
    assign state_dbg = state_q;

    assign imm_s  = {{(WIDTH-8){imm8[7]}}, imm8};
    assign imm_z  = WIDTH'(imm8);
    assign imm_sh = WIDTH'({ir_q[4], ir_q[3:0]});

    cond_eval u_cond_eval (
        .cond_i  (ir_q[11:8]),
        .psr_i   (psr_q),
        .taken_o (taken)
    );

    // State, IR and PSR registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_FETCH;
            ir_q    <= '0;
            psr_q   <= '0;
        end else begin
            state_q <= state_d;
            psr_q   <= psr_d;
            if (ir_en) begin
                ir_q <= mem_rdata;
            end
        end
    end

    // Next-state, datapath controls and PSR update
    always_comb begin
        state_d  = state_q;
        psr_d    = psr_q;
        ir_en    = 1'b0;
        alucont  = ALU_ADD;
        imm      = '0;
        use_imm  = 1'b0;
        reg_we   = 1'b0;
        wb_sel   = WB_ALU;
        addr_sel = 1'b0;
        mem_we   = 1'b0;
        pc_en    = 1'b0;
        pc_sel   = PC_INC;

        case (state_q)
            ST_FETCH: state_d = ST_DECODE;
            ST_DECODE: begin
                ir_en   = 1'b1;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                pc_en   = 1'b1;
                state_d = ST_FETCH;
                case (op)
                    OP_REG: begin
                        case (ext)
                            EXT_ADD: begin reg_we = 1'b1; psr_d[1:0] = psr_in[1:0]; end
                            EXT_SUB: begin alucont = ALU_SUB; reg_we = 1'b1; psr_d[1:0] = psr_in[1:0]; end
                            EXT_CMP: begin alucont = ALU_CMP; psr_d[4:2] = psr_in[4:2]; end
                            EXT_AND: begin alucont = ALU_AND; reg_we = 1'b1; end
                            EXT_OR:  begin alucont = ALU_OR;  reg_we = 1'b1; end
                            EXT_XOR: begin alucont = ALU_XOR; reg_we = 1'b1; end
                            EXT_MOV: begin alucont = ALU_MOV; reg_we = 1'b1; end
                            default: ;
                        endcase
                    end
                    OP_ADDI: begin use_imm = 1'b1; imm = imm_s; reg_we = 1'b1; psr_d[1:0] = psr_in[1:0]; end
                    OP_SUBI: begin alucont = ALU_SUB; use_imm = 1'b1; imm = imm_s; reg_we = 1'b1; psr_d[1:0] = psr_in[1:0]; end
                    OP_CMPI: begin alucont = ALU_CMP; use_imm = 1'b1; imm = imm_s; psr_d[4:2] = psr_in[4:2]; end
                    OP_MOVI: begin alucont = ALU_MOV; use_imm = 1'b1; imm = imm_s; reg_we = 1'b1; end
                    OP_ANDI: begin alucont = ALU_AND; use_imm = 1'b1; imm = imm_z; reg_we = 1'b1; end
                    OP_ORI:  begin alucont = ALU_OR;  use_imm = 1'b1; imm = imm_z; reg_we = 1'b1; end
                    OP_XORI: begin alucont = ALU_XOR; use_imm = 1'b1; imm = imm_z; reg_we = 1'b1; end
                    OP_LUI:  begin alucont = ALU_LUI; use_imm = 1'b1; imm = imm_z; reg_we = 1'b1; end
                    OP_RANI: begin alucont = ALU_RANI; use_imm = 1'b1; imm = imm_z; reg_we = 1'b1; end
                    OP_SHIFT: begin
                        if (ext == EXT_LSH) begin
                            alucont = ALU_LSH;
                            reg_we  = 1'b1;
                        end else if (ext[3:1] == 3'b000) begin
                            alucont = ALU_LSHI;
                            use_imm = 1'b1;
                            imm     = imm_sh;
                            reg_we  = 1'b1;
                        end
                    end
                    OP_MEM: begin
                        case (ext)
                            EXT_LOAD: begin
                                addr_sel = 1'b1;
                                pc_en    = 1'b0;
                                state_d  = ST_LOAD_WB;
                            end
                            EXT_STOR: begin addr_sel = 1'b1; mem_we = 1'b1; end
                            EXT_JCOND: begin
                                if (taken) pc_sel = PC_REG;
                            end
                            EXT_JAL: begin reg_we = 1'b1; wb_sel = WB_PC1; pc_sel = PC_REG; end
                            default: ;
                        endcase
                    end
                    OP_BCOND: begin
                        imm = imm_s;
                        if (taken) pc_sel = PC_DISP;
                    end
                    default: ;
                endcase
            end
            ST_LOAD_WB: begin
                reg_we  = 1'b1;
                wb_sel  = WB_MEM;
                pc_en   = 1'b1;
                state_d = ST_FETCH;
            end
            default: state_d = ST_FETCH;
        endcase

        // Reset aborts the instruction: no writes of any kind this cycle
        if (reset) begin
            state_d  = ST_FETCH;
            psr_d    = '0;
            ir_en    = 1'b0;
            alucont  = ALU_ADD;
            imm      = '0;
            use_imm  = 1'b0;
            reg_we   = 1'b0;
            wb_sel   = WB_ALU;
            addr_sel = 1'b0;
            mem_we   = 1'b0;
            pc_en    = 1'b0;
            pc_sel   = PC_INC;
        end
    end

endmodule

// File: tb/tb_cpu_controller.sv
// Self-checking bench for cpu_controller: table of instructions with
// expected EXEC-cycle controls and PSR, plus LOAD and reset corner cases.
module tb_cpu_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] mem_rdata;
    logic [4:0]  psr_in;
    logic [3:0]  alucont, rdest_sel, rsrc_sel;
    logic [15:0] imm;
    logic        use_imm, reg_we, ir_en, addr_sel, mem_we, pc_en;
    logic [1:0]  wb_sel, pc_sel;
    logic [4:0]  psr_q;
    logic [2:0]  state_dbg;

    cpu_controller dut (
        .clk       (clk),
        .reset     (reset),
        .mem_rdata (mem_rdata),
        .psr_in    (psr_in),
        .alucont   (alucont),
        .rdest_sel (rdest_sel),
        .rsrc_sel  (rsrc_sel),
        .imm       (imm),
        .use_imm   (use_imm),
        .reg_we    (reg_we),
        .wb_sel    (wb_sel),
        .ir_en     (ir_en),
        .addr_sel  (addr_sel),
        .mem_we    (mem_we),
        .pc_en     (pc_en),
        .pc_sel    (pc_sel),
        .psr_q     (psr_q),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] instr;
        logic [4:0]  psr_in;
        logic [3:0]  alu;
        logic [15:0] imm;
        logic        use_imm;
        logic        chk_imm;
        logic        reg_we;
        logic        mem_we;
        logic        addr_sel;
        logic [1:0]  pc_sel;
        logic [1:0]  wb_sel;
        logic [4:0]  psr_after;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   nerr = 0;
    int   nchk = 0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic [15:0] i, input logic [4:0] p, input logic [3:0] a,
                       input logic [15:0] im, input logic ui, input logic ci,
                       input logic rw, input logic mw, input logic as,
                       input logic [1:0] ps, input logic [1:0] wb, input logic [4:0] pa);
        vec_t v;
        v.instr = i; v.psr_in = p; v.alu = a; v.imm = im; v.use_imm = ui; v.chk_imm = ci;
        v.reg_we = rw; v.mem_we = mw; v.addr_sel = as; v.pc_sel = ps; v.wb_sel = wb;
        v.psr_after = pa;
        vecs.push_back(v);
    endtask

    initial begin
        vec_t e;
        int   pcen;

        //   instr     psr_in    alu      imm       ui ci  rw mw as pc     wb     psr_after
        add(16'h53FF, 5'b00011, 4'b0000, 16'hFFFF, 1, 1,  1, 0, 0, 2'b00, 2'b00, 5'b00011); // ADDI R3,#-1
        add(16'h01B2, 5'b01000, 4'b0101, 16'h0000, 0, 1,  0, 0, 0, 2'b00, 2'b00, 5'b01011); // CMP
        add(16'hC004, 5'b10111, 4'b0000, 16'h0000, 0, 0,  0, 0, 0, 2'b01, 2'b00, 5'b01011); // BEQ taken
        add(16'hC104, 5'b00000, 4'b0000, 16'h0000, 0, 0,  0, 0, 0, 2'b00, 2'b00, 5'b01011); // BNE not taken
        add(16'hCF04, 5'b11111, 4'b0000, 16'h0000, 0, 0,  0, 0, 0, 2'b00, 2'b00, 5'b01011); // never
        add(16'hCE04, 5'b00000, 4'b0000, 16'h0000, 0, 0,  0, 0, 0, 2'b01, 2'b00, 5'b01011); // always
        add(16'h8113, 5'b11111, 4'b1000, 16'h0013, 1, 1,  1, 0, 0, 2'b00, 2'b00, 5'b01011); // LSHI
        add(16'hE155, 5'b11111, 4'b1111, 16'h0000, 0, 0,  1, 0, 0, 2'b00, 2'b00, 5'b01011); // RANI
        add(16'h7000, 5'b11111, 4'b0000, 16'h0000, 0, 1,  0, 0, 0, 2'b00, 2'b00, 5'b01011); // undefined
        add(16'h9201, 5'b11101, 4'b0001, 16'h0001, 1, 1,  1, 0, 0, 2'b00, 2'b00, 5'b01001); // SUBI
        add(16'h1280, 5'b11111, 4'b0010, 16'h0080, 1, 1,  1, 0, 0, 2'b00, 2'b00, 5'b01001); // ANDI zext
        add(16'hB2FF, 5'b10100, 4'b0101, 16'hFFFF, 1, 1,  0, 0, 0, 2'b00, 2'b00, 5'b10101); // CMPI
        add(16'hF3AB, 5'b00000, 4'b1001, 16'h00AB, 1, 1,  1, 0, 0, 2'b00, 2'b00, 5'b10101); // LUI
        add(16'h46C5, 5'b00000, 4'b0000, 16'h0000, 0, 0,  0, 0, 0, 2'b10, 2'b00, 5'b10101); // JGT taken
        add(16'h4AC5, 5'b01000, 4'b0000, 16'h0000, 0, 0,  0, 0, 0, 2'b00, 2'b00, 5'b10101); // JLO not taken
        add(16'h4385, 5'b00000, 4'b0000, 16'h0000, 0, 0,  1, 0, 0, 2'b10, 2'b10, 5'b10101); // JAL
        add(16'h4245, 5'b00000, 4'b0000, 16'h0000, 0, 0,  0, 1, 1, 2'b00, 2'b00, 5'b10101); // STOR
        add(16'h01D2, 5'b11111, 4'b0110, 16'h0000, 0, 1,  1, 0, 0, 2'b00, 2'b00, 5'b10101); // MOV
        add(16'h0132, 5'b11111, 4'b0011, 16'h0000, 0, 1,  1, 0, 0, 2'b00, 2'b00, 5'b10101); // XOR
        add(16'h0152, 5'b00010, 4'b0000, 16'h0000, 0, 1,  1, 0, 0, 2'b00, 2'b00, 5'b10110); // ADD

        reset     = 1'b1;
        mem_rdata = 16'h0000;
        psr_in    = 5'b00000;
        tick;
        tick;
        chk("rst_state", 16'(state_dbg), 16'h0);
        chk("rst_psr", 16'(psr_q), 16'h0);
        chk("rst_strobes", {12'h0, reg_we, mem_we, pc_en, ir_en}, 16'h0);
        reset = 1'b0;

        foreach (vecs[k]) begin
            pcen = 0;
            chk("fetch_state", 16'(state_dbg), 16'h0);
            chk("fetch_strobes", {12'h0, reg_we, mem_we, ir_en, addr_sel}, 16'h0);
            pcen += int'(pc_en);
            mem_rdata = vecs[k].instr;
            sb.push_back(vecs[k]);
            tick;
            chk("decode_state", 16'(state_dbg), 16'h1);
            chk("decode_ir_en", 16'(ir_en), 16'h1);
            pcen += int'(pc_en);
            tick;
            psr_in = vecs[k].psr_in;
            #1;
            e = sb.pop_front();
            chk("exec_state", 16'(state_dbg), 16'h2);
            chk("exec_alucont", 16'(alucont), 16'(e.alu));
            if (e.chk_imm) begin
                chk("exec_imm", imm, e.imm);
                chk("exec_use_imm", 16'(use_imm), 16'(e.use_imm));
            end
            chk("exec_reg_we", 16'(reg_we), 16'(e.reg_we));
            chk("exec_mem_we", 16'(mem_we), 16'(e.mem_we));
            chk("exec_addr_sel", 16'(addr_sel), 16'(e.addr_sel));
            chk("exec_pc_sel", 16'(pc_sel), 16'(e.pc_sel));
            chk("exec_wb_sel", 16'(wb_sel), 16'(e.wb_sel));
            pcen += int'(pc_en);
            tick;
            chk("psr_after", 16'(psr_q), 16'(e.psr_after));
            chk("next_fetch", 16'(state_dbg), 16'h0);
            chk("pc_en_once", 16'(pcen), 16'h1);
        end

        // LOAD R2,(R5): four-cycle sequence with write-back in LOAD_WB
        pcen = 0;
        mem_rdata = 16'h4205;
        pcen += int'(pc_en);
        tick;
        pcen += int'(pc_en);
        tick;
        chk("ld_exec_addr_sel", 16'(addr_sel), 16'h1);
        chk("ld_exec_reg_we", 16'(reg_we), 16'h0);
        pcen += int'(pc_en);
        tick;
        chk("ld_wb_state", 16'(state_dbg), 16'h3);
        chk("ld_wb_reg_we", 16'(reg_we), 16'h1);
        chk("ld_wb_sel", 16'(wb_sel), 16'h1);
        chk("ld_wb_pc_sel", 16'(pc_sel), 16'h0);
        pcen += int'(pc_en);
        tick;
        chk("ld_pc_en_once", 16'(pcen), 16'h1);
        chk("ld_next_fetch", 16'(state_dbg), 16'h0);
        chk("ld_psr_kept", 16'(psr_q), 16'h16);

        // Reset held two cycles in the EXEC cycle of a STOR
        mem_rdata = 16'h4245;
        tick;
        tick;
        chk("rs_in_exec", 16'(state_dbg), 16'h2);
        reset = 1'b1;
        #1;
        chk("rs_mem_we0", 16'(mem_we), 16'h0);
        chk("rs_pc_en0", 16'(pc_en), 16'h0);
        tick;
        chk("rs_state", 16'(state_dbg), 16'h0);
        chk("rs_psr", 16'(psr_q), 16'h0);
        chk("rs_mem_we1", 16'(mem_we), 16'h0);
        tick;
        reset = 1'b0;
        chk("rs_ir_clr", 16'(rdest_sel), 16'h0);
        tick;
        chk("rs_decode", 16'(state_dbg), 16'h1);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
